// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared core widths, exception codes and MS->WS bus layout.
package wb_stage_pkg;
  localparam int RF_AW   = 5;
  localparam int DW      = 32;
  localparam int ECODE_W = 6;
  localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h08;
  localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;
  localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
  localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
  localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;
  localparam int MS_ECODE_OFS  = 0;
  localparam int MS_EX_OFS     = MS_ECODE_OFS + ECODE_W;
  localparam int MS_RESULT_OFS = MS_EX_OFS + 1;
  localparam int MS_DEST_OFS   = MS_RESULT_OFS + DW;
  localparam int MS_RF_WE_OFS  = MS_DEST_OFS + RF_AW;
  localparam int MS_PC_OFS     = MS_RF_WE_OFS + 1;
  localparam int MS_WS_BUS_W   = MS_PC_OFS + DW;
  function automatic logic [MS_WS_BUS_W-1:0] pack_ms(
    input logic [DW-1:0] pc, input logic rf_we, input logic [RF_AW-1:0] dest,
    input logic [DW-1:0] result, input logic ex, input logic [ECODE_W-1:0] ecode);
    return {pc, rf_we, dest, result, ex, ecode};
  endfunction
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: memory-to-writeback valid/allowin handshake and payload.
interface wb_stage_if;
  import wb_stage_pkg::*;
  logic               ms_to_ws_valid;
  logic               ws_allowin;
  logic [DW-1:0]      ms_pc;
  logic               ms_rf_we;
  logic [RF_AW-1:0]   ms_dest;
  logic [DW-1:0]      ms_result;
  logic               ms_ex;
  logic [ECODE_W-1:0] ms_ecode;
  modport master(output ms_to_ws_valid, ms_pc, ms_rf_we, ms_dest, ms_result, ms_ex, ms_ecode,
                 input ws_allowin);
  modport slave(input ms_to_ws_valid, ms_pc, ms_rf_we, ms_dest, ms_result, ms_ex, ms_ecode,
                output ws_allowin);
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback stage driving GPR write, bypass, exception commit, trace and retire count.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  wb_stage_if.slave          ms,
  output logic               rf_we,
  output logic [RF_AW-1:0]   rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic               ws_fwd_valid,
  output logic [RF_AW-1:0]   ws_fwd_dest,
  output logic [DW-1:0]      ws_fwd_data,
  output logic               wb_ex,
  output logic [ECODE_W-1:0] wb_ecode,
  output logic [DW-1:0]      wb_pc,
  output logic               ws_flush,
  output logic [31:0]        retire_cnt,
  output logic [DW-1:0]      debug_wb_pc,
  output logic [3:0]         debug_wb_rf_we,
  output logic [RF_AW-1:0]   debug_wb_rf_wnum,
  output logic [DW-1:0]      debug_wb_rf_wdata
);
  localparam logic ws_ready_go = 1'b1;
  logic                   ws_valid;
  logic                   allowin;
  logic                   accept;
  logic [MS_WS_BUS_W-1:0] ws_bus;
  logic [DW-1:0]          ws_pc;
  logic [DW-1:0]          ws_result;
  logic [RF_AW-1:0]       ws_dest;
  logic [ECODE_W-1:0]     ws_ecode;
  logic                   ws_rf_we;
  logic                   ws_ex;
  assign ws_pc    = ws_bus[MS_PC_OFS +: DW];
  assign ws_rf_we = ws_bus[MS_RF_WE_OFS];
  assign ws_dest  = ws_bus[MS_DEST_OFS +: RF_AW];
  assign ws_result = ws_bus[MS_RESULT_OFS +: DW];
  assign ws_ex    = ws_bus[MS_EX_OFS];
  assign ws_ecode = ws_bus[MS_ECODE_OFS +: ECODE_W];
  assign allowin       = !reset && (!ws_valid || ws_ready_go);
  assign ms.ws_allowin = allowin;
  assign ws_flush      = ws_valid && ws_ex;
  assign accept        = ms.ms_to_ws_valid && allowin && !ws_flush;
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid   <= 1'b0;
      ws_bus     <= '0;
      retire_cnt <= '0;
    end else begin
      if (allowin) ws_valid <= ms.ms_to_ws_valid && !ws_flush;
      if (accept) ws_bus <= pack_ms(ms.ms_pc, ms.ms_rf_we, ms.ms_dest, ms.ms_result, ms.ms_ex, ms.ms_ecode);
      if (ws_valid && !ws_ex) retire_cnt <= retire_cnt + 32'd1;
    end
  end
  // r0 writes are suppressed here too so the trace never shows them
  assign rf_we             = ws_valid && ws_rf_we && !ws_ex && (ws_dest != '0);
  assign rf_waddr          = ws_dest;
  assign rf_wdata          = ws_result;
  assign ws_fwd_valid      = rf_we;
  assign ws_fwd_dest       = ws_dest;
  assign ws_fwd_data       = ws_result;
  assign wb_ex             = ws_flush;
  assign wb_ecode          = ws_ecode;
  assign wb_pc             = ws_pc;
  assign debug_wb_pc       = ws_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = ws_dest;
  assign debug_wb_rf_wdata = ws_result;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed table-driven checks of wb_stage plus exception, wrap and reset sequences.
module tb_wb_stage;
  import wb_stage_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic               rf_we, ws_fwd_valid, wb_ex, ws_flush;
  logic [RF_AW-1:0]   rf_waddr, ws_fwd_dest, debug_wb_rf_wnum;
  logic [DW-1:0]      rf_wdata, ws_fwd_data, wb_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [ECODE_W-1:0] wb_ecode;
  logic [31:0]        retire_cnt;
  logic [3:0]         debug_wb_rf_we;
  int total = 0;
  int bad = 0;
  wb_stage_if bus();
  wb_stage dut (
    .clk(clk), .reset(reset), .ms(bus.slave),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_fwd_valid(ws_fwd_valid), .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_pc(wb_pc), .ws_flush(ws_flush),
    .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] res;
    logic        e_we;
    logic [31:0] e_cnt;
  } vec_t;
  vec_t tbl[8];
  logic [ECODE_W-1:0] codes[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic we, input logic [4:0] dest,
                       input logic [31:0] res, input logic ex, input logic [ECODE_W-1:0] ec);
    bus.ms_to_ws_valid = v;
    bus.ms_pc = pc;
    bus.ms_rf_we = we;
    bus.ms_dest = dest;
    bus.ms_result = res;
    bus.ms_ex = ex;
    bus.ms_ecode = ec;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0] = '{1'b1, 32'h1c000000, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'd0};
    tbl[1] = '{1'b1, 32'h1c000004, 1'b1, 5'd0, 32'h12345678, 1'b0, 32'd1};
    tbl[2] = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 32'd2};
    tbl[3] = '{1'b1, 32'h1c000020, 1'b1, 5'd1, 32'd1,        1'b1, 32'd2};
    tbl[4] = '{1'b1, 32'h1c000024, 1'b1, 5'd2, 32'd2,        1'b1, 32'd3};
    tbl[5] = '{1'b1, 32'h1c000028, 1'b1, 5'd3, 32'd3,        1'b1, 32'd4};
    tbl[6] = '{1'b1, 32'h1c00002c, 1'b1, 5'd4, 32'd4,        1'b1, 32'd5};
    tbl[7] = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 32'd6};
    codes = '{ECODE_SYS, ECODE_BRK, ECODE_INE, ECODE_ADEF, ECODE_ALE};
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, '0);
    repeat (3) step();
    chk("rst_allowin", 32'(bus.ws_allowin), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_dbg_pc", debug_wb_pc, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    reset = 1'b0;
    step();
    chk("idle_allowin", 32'(bus.ws_allowin), 32'd1);
    chk("idle_rf_we", 32'(rf_we), 32'd0);
    chk("idle_dbg_we", 32'(debug_wb_rf_we), 32'd0);
    chk("idle_wb_ex", 32'(wb_ex), 32'd0);
    chk("idle_cnt", retire_cnt, 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].pc, tbl[i].we, tbl[i].dest, tbl[i].res, 1'b0, '0);
      step();
      chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_fwd_valid", i), 32'(ws_fwd_valid), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_dbg_we", i), 32'(debug_wb_rf_we), 32'({4{tbl[i].e_we}}));
      chk($sformatf("v%0d_wb_ex", i), 32'(wb_ex), 32'd0);
      chk($sformatf("v%0d_cnt", i), retire_cnt, tbl[i].e_cnt);
      if (tbl[i].v) begin
        chk($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(tbl[i].dest));
        chk($sformatf("v%0d_wdata", i), rf_wdata, tbl[i].res);
        chk($sformatf("v%0d_fwd_data", i), ws_fwd_data, tbl[i].res);
        chk($sformatf("v%0d_dbg_pc", i), debug_wb_pc, tbl[i].pc);
        chk($sformatf("v%0d_dbg_wnum", i), 32'(debug_wb_rf_wnum), 32'(tbl[i].dest));
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1c000010 + 32'(i * 16), 1'b1, 5'd7, 32'hAAAA0000, 1'b1, codes[i]);
      step();
      chk($sformatf("ex%0d_wb_ex", i), 32'(wb_ex), 32'd1);
      chk($sformatf("ex%0d_flush", i), 32'(ws_flush), 32'd1);
      chk($sformatf("ex%0d_ecode", i), 32'(wb_ecode), 32'(codes[i]));
      chk($sformatf("ex%0d_wb_pc", i), wb_pc, 32'h1c000010 + 32'(i * 16));
      chk($sformatf("ex%0d_rf_we", i), 32'(rf_we), 32'd0);
      drive(1'b1, 32'h1c000014 + 32'(i * 16), 1'b1, 5'd8, 32'h55555555, 1'b0, '0);
      step();
      chk($sformatf("ex%0d_drop_rf_we", i), 32'(rf_we), 32'd0);
      chk($sformatf("ex%0d_drop_wb_ex", i), 32'(wb_ex), 32'd0);
      chk($sformatf("ex%0d_drop_pc", i), debug_wb_pc, 32'h1c000010 + 32'(i * 16));
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, '0);
      step();
      chk($sformatf("ex%0d_cnt", i), retire_cnt, 32'd6);
    end
    @(negedge clk);
    force dut.retire_cnt = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt;
    drive(1'b1, 32'h1c000100, 1'b1, 5'd9, 32'h0000CAFE, 1'b0, '0);
    step();
    chk("wrap_pre", retire_cnt, 32'hFFFFFFFF);
    chk("wrap_rf_we", 32'(rf_we), 32'd1);
    drive(1'b1, 32'h1c000104, 1'b1, 5'd10, 32'h0000BEEF, 1'b0, '0);
    step();
    chk("wrap_cnt", retire_cnt, 32'd0);
    chk("held_rf_we", 32'(rf_we), 32'd1);
    reset = 1'b1;
    drive(1'b1, 32'h1c000108, 1'b1, 5'd11, 32'h0000F00D, 1'b0, '0);
    step();
    chk("midrst_rf_we", 32'(rf_we), 32'd0);
    chk("midrst_allowin", 32'(bus.ws_allowin), 32'd0);
    chk("midrst_dbg_pc", debug_wb_pc, 32'd0);
    chk("midrst_cnt", retire_cnt, 32'd0);
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, '0);
    step();
    chk("postrst_rf_we", 32'(rf_we), 32'd0);
    chk("postrst_allowin", 32'(bus.ws_allowin), 32'd1);
    chk("postrst_cnt", retire_cnt, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (writeback) pipeline stage of the 5-stage core.
- Accepts retiring instructions from the memory stage through a valid/allowin handshake and holds them in one pipeline register.
- Drives the register-file write port (we/waddr/wdata) and a bypass path back to decode.
- Commits exceptions to the CSR unit, emits a pipeline flush, drives the debug trace interface and keeps a retired-instruction counter.

Parameters:
- RF_AW, 5, register-file address width.
- DW, 32, data/PC width.
- ECODE_W, 6, exception code width.

Ports:
- clk  in  1  core clock, all state on posedge.
- reset  in  1  synchronous active-high reset.
- ms_to_ws_valid  in  1  memory stage presents an instruction.
- ws_allowin  out  1  WB can accept this cycle.
- ms_pc  in  DW  PC of incoming instruction.
- ms_rf_we  in  1  instruction writes a GPR.
- ms_dest  in  RF_AW  destination register number.
- ms_result  in  DW  final result (ALU/load/CSR).
- ms_ex  in  1  instruction carries an exception.
- ms_ecode  in  ECODE_W  exception code.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  RF_AW  register-file write address.
- rf_wdata  out  DW  register-file write data.
- ws_fwd_valid  out  1  bypass entry is valid.
- ws_fwd_dest  out  RF_AW  bypass destination.
- ws_fwd_data  out  DW  bypass data.
- wb_ex  out  1  exception commit pulse to CSR.
- wb_ecode  out  ECODE_W  committed exception code.
- wb_pc  out  DW  faulting PC (ERA).
- ws_flush  out  1  flush all younger stages.
- retire_cnt  out  32  count of retired non-excepting instructions.
- debug_wb_pc  out  DW  trace PC.
- debug_wb_rf_we  out  4  trace write strobe.
- debug_wb_rf_wnum  out  RF_AW  trace register number.
- debug_wb_rf_wdata  out  DW  trace write data.

Behaviour:
- Internal state: ws_valid plus a registered copy of all ms_* fields. ws_ready_go = 1.
- ws_allowin = !ws_valid || ws_ready_go, i.e. constant 1 outside reset.
- Handshake: on posedge with ws_allowin, ws_valid <= ms_to_ws_valid && !ws_flush. When ms_to_ws_valid && ws_allowin && !ws_flush, the payload registers load. Otherwise the payload holds and its value is don't-care when ws_valid = 0.
- Latency: an instruction accepted at edge N is visible on all outputs in cycle N (one register stage) and retires in that same cycle.
- rf_we = ws_valid && ws_rf_we && !ws_ex && (ws_dest != 0).
- rf_waddr = ws_dest; rf_wdata = ws_result.
- The register file ignores writes to r0; WB also suppresses them so the trace stays clean.
- Bypass: ws_fwd_valid = rf_we; ws_fwd_dest = ws_dest; ws_fwd_data = ws_result.
- Exception: wb_ex = ws_flush = ws_valid && ws_ex. wb_ecode = ws_ecode; wb_pc = ws_pc. Both are combinational, one cycle wide. The instruction never writes the GPR.
- Flush in the same cycle as a new arrival: the arriving instruction is dropped (ws_valid <= 0).
- Back-to-back exceptions: impossible by construction, because the flush kills the successor.
- retire_cnt increments by 1 each cycle with ws_valid && !ws_ex. It wraps 0xFFFFFFFF -> 0 without saturation.
- Debug trace:
  - debug_wb_pc = ws_pc.
  - debug_wb_rf_we = {4{rf_we}}.
  - debug_wb_rf_wnum = ws_dest.
  - debug_wb_rf_wdata = ws_result.
- Reset values (while reset = 1, and for the first cycle after):
  - ws_valid = 0; all payload registers = 0; retire_cnt = 0.
  - Hence rf_we = 0, wb_ex = 0, ws_flush = 0, ws_fwd_valid = 0, debug_wb_rf_we = 0, debug_wb_pc = 0.
  - ws_allowin = 0 during reset, 1 after.
- Reset mid-operation: the in-flight instruction is discarded with no GPR write. Reset has priority over load.

Decomposition:
- Shared package/header (cpu_defs): RF_AW, DW, ECODE_W, the ECODE_* constants (SYS, BRK, INE, ADEF, ALE), and the MS->WS bus field offsets. Other stages reuse these.
- No sub-module; the stage is one flat module.

Test Plan:
- Reset then idle: hold reset 3 cycles, release, no input -> ws_allowin = 1, rf_we = 0, retire_cnt = 0, debug_wb_rf_we = 0.
- Single write: pc = 0x1c000000, dest = 5, result = 0xDEADBEEF, rf_we = 1, valid one cycle -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF, ws_fwd_valid = 1, debug_wb_rf_we = 4'hF; retire_cnt = 1 after the following edge.
- r0 write: dest = 0, rf_we = 1, result = 0x12345678 -> rf_we = 0, debug_wb_rf_we = 0, retire_cnt still increments.
- Exception with simultaneous arrival: ms_ex = 1, ecode = 0x0B, pc = 0x1c000010, followed next cycle by a valid instruction at pc = 0x1c000014 -> wb_ex = ws_flush = 1, wb_pc = 0x1c000010, rf_we = 0; the 0x1c000014 instruction never appears on debug_wb_pc.
- Back-to-back stream: 4 consecutive valid writes r1..r4 with results 1..4 -> rf_we high 4 consecutive cycles with matching waddr/wdata; retire_cnt = 4.
- Counter wrap plus reset mid-flight: force retire_cnt to 0xFFFFFFFF, retire 1 -> retire_cnt = 0. Assert reset in the cycle an instruction is held -> no rf_we and ws_valid = 0 the next cycle.
